arr_access_sched: RTL and testbench

Round-robin scheduler that shares one DEPTH-entry array of 32-bit `int` words between NUM_REQ requesters. Each access is a single read or write. The block owns the array storage and serialises all accesses through a three-state FSM. It also exports the whole array as an unpacked-array output port, `arr_q[DEPTH]`, so that downstream modules with unpacked `int` array inputs can be driven from it directly. It sits between requester front-ends and any consumer of the shared table.

---
 rtl/arr_access_sched_pkg.sv | 24 ++
 rtl/arr_access_sched_if.sv | 30 +++
 rtl/arr_access_sched_rr_pick.sv | 26 ++
 rtl/arr_access_sched.sv | 112 +++++++++++
 tb/tb_arr_access_sched.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/arr_access_sched_pkg.sv
// Shared types and defaults for the round-robin array access scheduler.
// Optional address-error reporting is enabled with ARR_SCHED_ERR_EN.
package arr_sched_pkg;

  typedef int arr_word_t;

  localparam int ARR_SCHED_DEPTH   = 10;
  localparam int ARR_SCHED_NUM_REQ = 4;
  // Address is carried wide so out-of-range values survive for the range check.
  localparam int ARR_CMD_ADDR_W    = 16;

  typedef enum logic [1:0] {
    ARR_IDLE = 2'd0,
    ARR_BUSY = 2'd1,
    ARR_RESP = 2'd2
  } arr_sched_state_e;

  typedef struct packed {
    logic                      write;
    logic [ARR_CMD_ADDR_W-1:0] addr;
    arr_word_t                 wdata;
  } arr_cmd_t;

endpackage

// File: rtl/arr_access_sched_if.sv
// Requester-side bus of the array scheduler: request handshake plus response.
// rsp_err exists only when ARR_SCHED_ERR_EN is defined.
interface arr_sched_if
  import arr_sched_pkg::*;
#(
  parameter int NUM_REQ = ARR_SCHED_NUM_REQ,
  parameter int DEPTH   = ARR_SCHED_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH)
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  arr_word_t                      req_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  arr_word_t                      rsp_rdata;
`ifdef ARR_SCHED_ERR_EN
  logic                           rsp_err;

  modport master (output req_valid, req_write, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
`else
  modport master (output req_valid, req_write, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
`endif
endinterface

// File: rtl/arr_access_sched_rr_pick.sv
// Combinational round-robin picker: first set valid bit searching upward from ptr, wrapping.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);
  logic [IDX_W-1:0] cand;

  // Scan from the far end so the candidate closest to ptr is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/arr_access_sched.sv
// Round-robin scheduler serialising single read/write accesses to a shared int array.
// IDLE->BUSY->RESP, one access per 3 cycles; ARR_SCHED_ERR_EN adds the rsp_err flag.
module arr_access_sched
  import arr_sched_pkg::*;
#(
  parameter int NUM_REQ = ARR_SCHED_NUM_REQ,
  parameter int DEPTH   = ARR_SCHED_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  arr_sched_if.slave bus,
  output arr_word_t  arr_q [DEPTH]
);
  localparam int         IDX_W   = $clog2(NUM_REQ);
  localparam logic [1:0] ST_IDLE = ARR_IDLE;
  localparam logic [1:0] ST_BUSY = ARR_BUSY;
  localparam logic [1:0] ST_RESP = ARR_RESP;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  arr_cmd_t         cmd_q, cmd_d;
  arr_word_t        rdata_q, rdata_d;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             addr_ok;
  logic             accept;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign addr_ok = cmd_q.addr < ARR_CMD_ADDR_W'(DEPTH);
  // A requester that dropped valid before BUSY forfeits the access.
  assign accept  = (state_q == ST_BUSY) && bus.req_valid[gnt_q];

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cmd_d    = cmd_q;
    rr_ptr_d = rr_ptr_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d       = pick_idx;
          cmd_d.write = bus.req_write[pick_idx];
          cmd_d.addr  = ARR_CMD_ADDR_W'(bus.req_addr[pick_idx]);
          cmd_d.wdata = bus.req_wdata[pick_idx];
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        state_d = accept ? ST_RESP : ST_IDLE;
        if (accept) begin
          rdata_d = '0;
          if (addr_ok) begin
            rdata_d = cmd_q.write ? cmd_q.wdata : arr_q[cmd_q.addr[ADDR_W-1:0]];
          end
        end
      end
      ST_RESP: begin
        rr_ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (accept) bus.req_ready[gnt_q] = 1'b1;
    if (state_q == ST_RESP) bus.rsp_valid[gnt_q] = 1'b1;
  end

  assign bus.rsp_rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      cmd_q    <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) arr_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      cmd_q    <= cmd_d;
      rdata_q  <= rdata_d;
      if (accept && cmd_q.write && addr_ok) arr_q[cmd_q.addr[ADDR_W-1:0]] <= cmd_q.wdata;
    end
  end

`ifdef ARR_SCHED_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= !addr_ok;
  end

  assign bus.rsp_err = err_q;
`endif

endmodule

// File: tb/tb_arr_access_sched.sv
// Directed bench for arr_access_sched: reset, write/read, fairness, contention, mid-access reset, out-of-range.
module tb_arr_access_sched;
  import arr_sched_pkg::*;

  localparam int NR = 4;
  localparam int DP = 10;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  arr_word_t arr_q [DP];
  int        n_checks = 0;
  int        n_pass   = 0;

  arr_sched_if #(.NUM_REQ(NR), .DEPTH(DP)) bus ();

  arr_access_sched #(.NUM_REQ(NR), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .arr_q (arr_q)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input int r, input bit wr, input int addr, input int wdata,
                           input logic [31:0] exp_rdata);
    logic [NR-1:0] oh;
    oh = NR'(1) << r;
    bus.req_valid[r] = 1'b1;
    bus.req_write[r] = wr;
    bus.req_addr[r]  = 4'(addr);
    bus.req_wdata[r] = wdata;
    tick();
    check_eq("ready_at_n1", 32'(bus.req_ready), 32'(oh));
    check_eq("rspv_at_n1", 32'(bus.rsp_valid), 32'd0);
    tick();
    check_eq("rspv_at_n2", 32'(bus.rsp_valid), 32'(oh));
    check_eq("ready_at_n2", 32'(bus.req_ready), 32'd0);
    check_eq("rdata", bus.rsp_rdata, exp_rdata);
    if (wr && addr < DP) check_eq("arr_after_wr", arr_q[addr], wdata);
`ifdef ARR_SCHED_ERR_EN
    check_eq("rsp_err", 32'(bus.rsp_err), (addr >= DP) ? 32'd1 : 32'd0);
`endif
    bus.req_valid[r] = 1'b0;
    tick();
    check_eq("rspv_at_n3", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int order [6];
    logic [31:0] snap [DP];
    order = '{0, 1, 2, 3, 0, 1};
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    for (int i = 0; i < NR; i++) bus.req_wdata[i] = 0;

    // Reset
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < DP; i++) check_eq("reset_arr", arr_q[i], 32'd0);
    check_eq("reset_rdata", bus.rsp_rdata, 32'd0);
`ifdef ARR_SCHED_ERR_EN
    check_eq("reset_err", 32'(bus.rsp_err), 32'd0);
`endif
    for (int c = 0; c < 5; c++) begin
      check_eq("idle_ready", 32'(bus.req_ready), 32'd0);
      check_eq("idle_rspv", 32'(bus.rsp_valid), 32'd0);
      tick();
    end

    // Fairness: all four held valid, each writes addr i = 100+i
    for (int i = 0; i < NR; i++) begin
      bus.req_write[i] = 1'b1;
      bus.req_addr[i]  = 4'(i);
      bus.req_wdata[i] = 100 + i;
    end
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 18; c++) begin
      tick();
      check_eq("fair_ready", 32'(bus.req_ready),
               (c % 3 == 0) ? (32'd1 << order[c / 3]) : 32'd0);
      check_eq("fair_rspv", 32'(bus.rsp_valid),
               (c % 3 == 1) ? (32'd1 << order[c / 3]) : 32'd0);
    end
    bus.req_valid = '0;
    check_eq("fair_arr3", arr_q[3], 32'd103);
    tick();

    // Single write then read by req0
    do_access(0, 1'b1, 3, 32'h1234_5678, 32'h1234_5678);
    do_access(0, 1'b0, 3, 0, 32'h1234_5678);

    // Contention: rr_ptr is now 1; req1 reads addr 9 while req2 writes 7 there
    bus.req_write[1] = 1'b0; bus.req_addr[1] = 4'd9;
    bus.req_write[2] = 1'b1; bus.req_addr[2] = 4'd9; bus.req_wdata[2] = 7;
    bus.req_valid = 4'b0110;
    tick();
    check_eq("cont_ready1", 32'(bus.req_ready), 32'b0010);
    tick();
    check_eq("cont_rspv1", 32'(bus.rsp_valid), 32'b0010);
    check_eq("cont_rdata1", bus.rsp_rdata, 32'd0);
    bus.req_valid[1] = 1'b0;
    tick();
    tick();
    check_eq("cont_ready2", 32'(bus.req_ready), 32'b0100);
    tick();
    check_eq("cont_rspv2", 32'(bus.rsp_valid), 32'b0100);
    check_eq("cont_rdata2", bus.rsp_rdata, 32'd7);
    check_eq("cont_arr9", arr_q[9], 32'd7);
    bus.req_valid[2] = 1'b0;
    tick();

    // Reset asserted while req3's write is in BUSY
    bus.req_write[3] = 1'b1; bus.req_addr[3] = 4'd5; bus.req_wdata[3] = 32'h55;
    bus.req_valid[3] = 1'b1;
    tick();
    check_eq("mid_busy_ready", 32'(bus.req_ready), 32'b1000);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid[3] = 1'b0;
    tick();
    check_eq("mid_rst_rspv", 32'(bus.rsp_valid), 32'd0);
    check_eq("mid_rst_arr5", arr_q[5], 32'd0);
    check_eq("mid_rst_arr3", arr_q[3], 32'd0);
    check_eq("mid_rst_arr9", arr_q[9], 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_rspv", 32'(bus.rsp_valid), 32'd0);
    do_access(2, 1'b1, 5, 32'hAA, 32'hAA);

    // Out-of-range write: array unchanged, handshake timing intact
    for (int i = 0; i < DP; i++) snap[i] = (i == 5) ? 32'hAA : 32'd0;
    do_access(1, 1'b1, 12, 32'hDEAD, 32'd0);
    for (int i = 0; i < DP; i++) check_eq("oor_arr", arr_q[i], snap[i]);
    do_access(1, 1'b0, 12, 0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
